// File: rtl/mdr_mem_sequencer.sv
// Sequences every data-memory access through the 8-bit MDR: read/load strobes, memory enable/we, done pulse.
// Optional macro MEM_READY_EN adds a mem_ready handshake port that replaces the fixed MEM_LAT wait.
module mdr_mem_sequencer #(
  parameter int MEM_LAT = 2,
  parameter int LAT_W   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rd_req,
  input  logic       wr_req,
`ifdef MEM_READY_EN
  input  logic       mem_ready,
`endif
  output logic       busy,
  output logic       done,
  output logic       mdr_read,
  output logic       mdr_load,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] acc_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_RD_CAPT = 3'd2,
    S_WR_LOAD = 3'd3,
    S_WR_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LAT_W-1:0] r_lat_cnt;
  logic [LAT_W-1:0] w_lat_cnt_nxt;
  logic             w_wait_over;
  logic             r_busy;
  logic             r_done;
  logic             r_mdr_read;
  logic             r_mdr_load;
  logic             r_mem_en;
  logic             r_mem_we;
  logic [7:0]       r_acc_cnt;

`ifdef MEM_READY_EN
  assign w_wait_over = mem_ready;
`else
  assign w_wait_over = (r_lat_cnt == LAT_W'(MEM_LAT - 1));
`endif

  // Next-state and latency-counter logic; the counter restarts on every entry to a wait state.
  always_comb begin
    w_state_nxt   = r_state;
    w_lat_cnt_nxt = r_lat_cnt;
    case (r_state)
      S_IDLE: begin
        if (rd_req) begin
          w_state_nxt   = S_RD_WAIT;
          w_lat_cnt_nxt = '0;
        end else if (wr_req) begin
          w_state_nxt   = S_WR_LOAD;
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_RD_WAIT: begin
        if (w_wait_over) begin
          w_state_nxt   = S_RD_CAPT;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + LAT_W'(1);
        end
      end
      S_RD_CAPT: w_state_nxt = S_DONE;
      S_WR_LOAD: begin
        w_state_nxt   = S_WR_WAIT;
        w_lat_cnt_nxt = '0;
      end
      S_WR_WAIT: begin
        if (w_wait_over) begin
          w_state_nxt   = S_DONE;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + LAT_W'(1);
        end
      end
      S_DONE:    w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt   = S_IDLE;
        w_lat_cnt_nxt = '0;
      end
    endcase
  end

  // State and latency counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
    end
  end

  // Outputs are registered from the next state, so each one is a pure function of the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mdr_read <= 1'b0;
      r_mdr_load <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
    end else begin
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      r_mdr_read <= (w_state_nxt == S_RD_CAPT);
      r_mdr_load <= (w_state_nxt == S_WR_LOAD);
      r_mem_en   <= (w_state_nxt == S_RD_WAIT) || (w_state_nxt == S_RD_CAPT) ||
                    (w_state_nxt == S_WR_WAIT);
      r_mem_we   <= (w_state_nxt == S_WR_WAIT);
    end
  end

  // Completed-access counter, bumped on the edge that leaves DONE; wraps naturally at 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt <= 8'd0;
    end else if (r_state == S_DONE) begin
      r_acc_cnt <= r_acc_cnt + 8'd1;
    end else begin
      r_acc_cnt <= r_acc_cnt;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign mdr_read = r_mdr_read;
  assign mdr_load = r_mdr_load;
  assign mem_en   = r_mem_en;
  assign mem_we   = r_mem_we;
  assign acc_cnt  = r_acc_cnt;

endmodule
